// File: rtl/booth2_div16_16_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : booth2_div16_16_seq_if
// Description : Operand/result handshake bundle for the sequential signed
//               divider. The master side issues dividend/divisor pairs and
//               consumes quotient/remainder. The slave side is the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth2_div16_16_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    // Requester side: drives operands and the result-accept strobe
    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero,
        input  overflow
    );

    // Divider side
    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/booth2_div16_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth2_div16_16_seq
// Description : Sequential signed WIDTH/WIDTH integer divider. Works on
//               operand magnitudes with one restoring step per clock, then
//               applies two's-complement sign correction. The quotient
//               truncates toward zero, and the remainder takes the sign of
//               the dividend.
// Revision    : 1.0 - initial release
// ============================================================================
module booth2_div16_16_seq #(
    parameter int WIDTH = 16
) (
    input  wire logic             sys_clk,
    input  wire logic             sys_rst_n,
    booth2_div16_16_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             sign_a_q,    sign_a_d;
    logic             sign_b_q,    sign_b_d;
    logic             ovf_pend_q,  ovf_pend_d;
    logic [WIDTH-1:0] quo_q,       quo_d;       // working quotient / dividend shifter
    logic [WIDTH:0]   rem_q,       rem_d;       // partial remainder
    logic [WIDTH-1:0] dvs_q,       dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Operand magnitudes. The most negative value maps onto itself, and that
    // bit pattern is the correct unsigned magnitude 2^(WIDTH-1).
    logic [WIDTH-1:0] w_dend_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    assign w_dend_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_dvs_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    // One restoring step. The top bit of the shifted value is always zero,
    // because the remainder stays below the divisor. A borrow out of the
    // subtraction therefore lands in the top bit of w_trial.
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_fits;
    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_trial = w_shift - {2'b00, dvs_q};
    assign w_fits  = ~w_trial[WIDTH+1];

    // Next-state and datapath decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        ovf_pend_d  = ovf_pend_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_a_d   = bus.dividend[WIDTH-1];
                    sign_b_d   = bus.divisor[WIDTH-1];
                    ovf_pend_d = (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                    quo_d      = w_dend_mag;
                    dvs_d      = w_dvs_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                    if (bus.divisor == '0) begin
                        // Skip the iteration entirely; the result is fixed
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                rem_d = w_fits ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
                quo_d = {quo_q[WIDTH-2:0], w_fits};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                quotient_d  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                remainder_d = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                dbz_d       = 1'b0;
                ovf_d       = ovf_pend_q;
                state_d     = S_DONE;
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs come from the next state only, so they are clean flops
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            ovf_pend_q  <= ovf_pend_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth2_div16_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth2_div16_16_seq
// Description : Self-checking bench for the sequential signed divider.
//               Table vectors, handshake corner sequences and random
//               operands are checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth2_div16_16_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth2_div16_16_seq_if #(.WIDTH(16)) bus();

    booth2_div16_16_seq #(.WIDTH(16)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;   // edges after the accepting edge until out_valid is seen
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer division, which truncates toward zero
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dbz, output logic ovf, output int lat);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = 16'hFFFF; r = a; dbz = 1'b1; ovf = 1'b0; lat = 0;
        end else begin
            q   = 16'(sa / sb);
            r   = 16'(sa % sb);
            dbz = 1'b0;
            ovf = (sa == -32768) && (sb == -1);
            lat = 17;
        end
    endfunction

    // Present an operation, wait for acceptance, then wait for out_valid.
    // Returns at posedge+1 with out_valid high (or after the bound expires).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        int g;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready",  32'(bus.in_ready),  32'd1);
    endtask

    task automatic check_result(input logic [15:0] q, input logic [15:0] r,
                                input logic dbz, input logic ovf, input int lat_exp, input int lat);
        chk("latency",     32'(lat),             32'(lat_exp));
        chk("quotient",    32'(bus.quotient),    32'(q));
        chk("remainder",   32'(bus.remainder),   32'(r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(dbz));
        chk("overflow",    32'(bus.overflow),    32'(ovf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] a, b, q, r;
        logic        dbz, ovf;
        int          elat;

        tbl[0]  = '{16'd100,   16'd7,      16'h000E, 16'h0002, 1'b0, 1'b0, 17};
        tbl[1]  = '{-16'sd100, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17};
        tbl[2]  = '{16'd100,   -16'sd7,    16'hFFF2, 16'h0002, 1'b0, 1'b0, 17};
        tbl[3]  = '{-16'sd100, -16'sd7,    16'h000E, 16'hFFFE, 1'b0, 1'b0, 17};
        tbl[4]  = '{16'h8000,  16'hFFFF,   16'h8000, 16'h0000, 1'b0, 1'b1, 17};
        tbl[5]  = '{16'd1234,  16'd0,      16'hFFFF, 16'h04D2, 1'b1, 1'b0, 0};
        tbl[6]  = '{16'h8000,  16'd1,      16'h8000, 16'h0000, 1'b0, 1'b0, 17};
        tbl[7]  = '{16'd7,     16'd100,    16'h0000, 16'h0007, 1'b0, 1'b0, 17};
        tbl[8]  = '{16'd0,     16'd5,      16'h0000, 16'h0000, 1'b0, 1'b0, 17};
        tbl[9]  = '{16'h8000,  16'd0,      16'hFFFF, 16'h8000, 1'b1, 1'b0, 0};
        tbl[10] = '{16'hFFFF,  16'd2,      16'h0000, 16'hFFFF, 1'b0, 1'b0, 17};
        tbl[11] = '{16'h7FFF,  16'h8000,   16'h0000, 16'h7FFF, 1'b0, 1'b0, 17};
        tbl[12] = '{16'h8000,  16'h8000,   16'h0001, 16'h0000, 1'b0, 1'b0, 17};
        tbl[13] = '{16'h8000,  16'd7,      16'hEDB7, 16'hFFFF, 1'b0, 1'b0, 17};

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),    32'd1);
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_quotient",  32'(bus.quotient),    32'd0);
        chk("rst_remainder", 32'(bus.remainder),   32'd0);
        chk("rst_dbz",       32'(bus.div_by_zero), 32'd0);
        chk("rst_ovf",       32'(bus.overflow),    32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].a, tbl[i].b, lat);
            check_result(tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf, tbl[i].lat, lat);
            release_result();
            chk("idle_hold_quotient", 32'(bus.quotient), 32'(tbl[i].q));
        end

        // Backpressure, then a back-to-back request offered during acceptance
        run_op(16'd32767, 16'd3, lat);
        chk("bp_latency", 32'(lat), 32'd17);
        for (int k = 0; k < 5; k++) begin
            chk("bp_quotient",  32'(bus.quotient),  32'd10922);
            chk("bp_remainder", 32'(bus.remainder), 32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 16'hFFFF;
        bus.divisor   = 16'd2;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("b2b_in_ready",  32'(bus.in_ready),  32'd1);
        chk("b2b_out_valid", 32'(bus.out_valid), 32'd0);
        chk("b2b_hold_q",    32'(bus.quotient),  32'd10922);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b_accepted", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_result(16'h0000, 16'hFFFF, 1'b0, 1'b0, 17, lat);
        release_result();

        // Reset in the middle of the iteration
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_in_ready",  32'(bus.in_ready),    32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("mid_rst_quotient",  32'(bus.quotient),    32'd0);
        chk("mid_rst_remainder", 32'(bus.remainder),   32'd0);
        chk("mid_rst_dbz",       32'(bus.div_by_zero), 32'd0);
        chk("mid_rst_ovf",       32'(bus.overflow),    32'd0);
        run_op(16'd50, 16'd5, lat);
        check_result(16'd10, 16'd0, 1'b0, 1'b0, 17, lat);
        release_result();

        // Random operands, biased toward the special divisors and dividends
        for (int n = 0; n < 60; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                2: a = 16'h8000;
                3: b = 16'($urandom_range(1, 9));
                default: ;
            endcase
            model(a, b, q, r, dbz, ovf, elat);
            run_op(a, b, lat);
            check_result(q, r, dbz, ovf, elat, lat);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                chk("rand_hold_q", 32'(bus.quotient), 32'(q));
            end
            release_result();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
